// File: rtl/bloom_filter_lut_cleaner_pkg.sv
// Shared definitions for the bloom-filter LUT cleaner.
//   HASH_CNT, LUT_ADDR_W, LUT_DATA_W : default geometry of the hash LUTs.
//   cleaner_state_t                  : cleaner FSM state encoding.
package bloom_filter_pkg;

  localparam int HASH_CNT   = 4;
  localparam int LUT_ADDR_W = 10;
  localparam int LUT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CLEAN,
    VERIFY
  } cleaner_state_t;

endpackage

// File: rtl/bloom_filter_lut_cleaner_if.sv
// External LUT-programming write port (valid/ready).
//   valid : write request, held stable with its payload until ready
//   ready : write accepted this cycle (driven by the cleaner)
//   sel   : one bit per target LUT
//   addr  : LUT word address
//   data  : LUT word
// Modports: master = write source, slave = cleaner.
interface bloom_filter_lut_cleaner_if #(
  parameter int HASH_CNT   = bloom_filter_pkg::HASH_CNT,
  parameter int LUT_ADDR_W = bloom_filter_pkg::LUT_ADDR_W,
  parameter int LUT_DATA_W = bloom_filter_pkg::LUT_DATA_W
);

  logic                  valid;
  logic                  ready;
  logic [HASH_CNT-1:0]   sel;
  logic [LUT_ADDR_W-1:0] addr;
  logic [LUT_DATA_W-1:0] data;

  modport master (output valid, sel, addr, data, input ready);
  modport slave  (input valid, sel, addr, data, output ready);

endinterface

// File: rtl/bloom_filter_lut_cleaner.sv
// Owner of the write port of the HASH_CNT hash LUTs.
// Zeroes every LUT address after reset and on each clean strobe, and
// forwards external programming writes while idle.
//
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   clean_stb_i      : one-cycle clean request
//   clean_done_o     : 1 = idle and clean, 0 = clean in progress
//   ext_wr           : external write port (slave side)
//   lut_wr_en_o      : per-LUT write enable (registered)
//   lut_wr_addr_o    : shared LUT write address (registered)
//   lut_wr_data_o    : shared LUT write data (registered)
//
// Optional feature macro BLOOM_FILTER_CLEAN_VERIFY_EN: after each clean the
// LUTs are read back over the full depth and any nonzero word sets the sticky
// clean_err_o. Adds lut_rd_en_o, lut_rd_addr_o, lut_rd_data_i, clean_err_o.
module bloom_filter_lut_cleaner #(
  parameter int HASH_CNT   = bloom_filter_pkg::HASH_CNT,
  parameter int LUT_ADDR_W = bloom_filter_pkg::LUT_ADDR_W,
  parameter int LUT_DATA_W = bloom_filter_pkg::LUT_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clean_stb_i,
  output logic                   clean_done_o,
  bloom_filter_lut_cleaner_if.slave ext_wr,
  output logic [HASH_CNT-1:0]    lut_wr_en_o,
  output logic [LUT_ADDR_W-1:0]  lut_wr_addr_o,
  output logic [LUT_DATA_W-1:0]  lut_wr_data_o
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
  ,
  output logic                           lut_rd_en_o,
  output logic [LUT_ADDR_W-1:0]          lut_rd_addr_o,
  input  logic [HASH_CNT*LUT_DATA_W-1:0] lut_rd_data_i,
  output logic                           clean_err_o
`endif
);

  import bloom_filter_pkg::*;

  localparam logic [LUT_ADDR_W-1:0] LAST_ADDR = {LUT_ADDR_W{1'b1}};
  localparam logic [LUT_ADDR_W-1:0] ONE_ADDR  = LUT_ADDR_W'(1);

  cleaner_state_t        state;
  logic [LUT_ADDR_W-1:0] cnt;
  logic                  accept;

`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
  logic chk_vld;  // read data for the previous cycle's read is valid now
  logic rd_tail;  // all reads issued, waiting one cycle for the last return
`endif

  // A strobe in the same cycle as a write request wins; the write waits.
  assign ext_wr.ready = (state == IDLE) && !clean_stb_i;
  assign accept       = ext_wr.valid && ext_wr.ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // Reset lands in CLEAN: LUT RAM contents are undefined at power-up.
      state         <= CLEAN;
      cnt           <= '0;
      clean_done_o  <= 1'b0;
      lut_wr_en_o   <= '0;
      lut_wr_addr_o <= '0;
      lut_wr_data_o <= '0;
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
      lut_rd_en_o   <= 1'b0;
      lut_rd_addr_o <= '0;
      chk_vld       <= 1'b0;
      rd_tail       <= 1'b0;
      clean_err_o   <= 1'b0;
`endif
    end else begin
      // NOTE: these are non-blocking defaults; a later assignment to the same
      // register in this block overrides them, so no else-branches are needed.
      lut_wr_en_o <= '0;
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
      lut_rd_en_o <= 1'b0;
      chk_vld     <= lut_rd_en_o && !clean_stb_i;
      if (chk_vld && (lut_rd_data_i != '0)) clean_err_o <= 1'b1;
`endif

      if (clean_stb_i) begin
        state        <= CLEAN;
        clean_done_o <= 1'b0;
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
        clean_err_o  <= 1'b0;
        rd_tail      <= 1'b0;
`endif
        if (state == IDLE) begin
          cnt <= '0;
        end else begin
          // Mid-clean/verify restart: address 0 goes out on this very edge.
          lut_wr_en_o   <= '1;
          lut_wr_addr_o <= '0;
          lut_wr_data_o <= '0;
          cnt           <= ONE_ADDR;
        end
      end else begin
        case (state)
          IDLE: begin
            clean_done_o <= 1'b1;
            if (accept) begin
              lut_wr_en_o   <= ext_wr.sel;
              lut_wr_addr_o <= ext_wr.addr;
              lut_wr_data_o <= ext_wr.data;
            end
          end
          CLEAN: begin
            lut_wr_en_o   <= '1;
            lut_wr_addr_o <= cnt;
            lut_wr_data_o <= '0;
            cnt           <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
              state <= VERIFY;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
          VERIFY: begin
            if (!rd_tail) begin
              lut_rd_en_o   <= 1'b1;
              lut_rd_addr_o <= cnt;
              cnt           <= cnt + 1'b1;
              if (cnt == LAST_ADDR) rd_tail <= 1'b1;
            end else begin
              // The last compare resolves on the next edge, together with
              // clean_done_o rising, so clean_err_o is final when done is seen.
              rd_tail <= 1'b0;
              state   <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bloom_filter_lut_cleaner.sv
// Directed bench for bloom_filter_lut_cleaner with LUT_ADDR_W=4, HASH_CNT=4.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bloom_filter_lut_cleaner;

  localparam int HASH_CNT   = 4;
  localparam int LUT_ADDR_W = 4;
  localparam int LUT_DATA_W = 32;
  localparam int DEPTH      = 1 << LUT_ADDR_W;
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
  localparam int EXTRA = DEPTH + 1;  // read-back pass after each clean
`else
  localparam int EXTRA = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  clean_stb = 1'b0;
  logic                  clean_done;
  logic [HASH_CNT-1:0]   lut_wr_en;
  logic [LUT_ADDR_W-1:0] lut_wr_addr;
  logic [LUT_DATA_W-1:0] lut_wr_data;
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
  logic                           lut_rd_en;
  logic [LUT_ADDR_W-1:0]          lut_rd_addr;
  logic [HASH_CNT*LUT_DATA_W-1:0] lut_rd_data = '0;
  logic                           clean_err;
  logic                           bad_word = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bloom_filter_lut_cleaner_if #(
    .HASH_CNT(HASH_CNT), .LUT_ADDR_W(LUT_ADDR_W), .LUT_DATA_W(LUT_DATA_W)
  ) ext_wr ();

  bloom_filter_lut_cleaner #(
    .HASH_CNT(HASH_CNT), .LUT_ADDR_W(LUT_ADDR_W), .LUT_DATA_W(LUT_DATA_W)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clean_stb_i   (clean_stb),
    .clean_done_o  (clean_done),
    .ext_wr        (ext_wr),
    .lut_wr_en_o   (lut_wr_en),
    .lut_wr_addr_o (lut_wr_addr),
    .lut_wr_data_o (lut_wr_data)
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
    ,
    .lut_rd_en_o   (lut_rd_en),
    .lut_rd_addr_o (lut_rd_addr),
    .lut_rd_data_i (lut_rd_data),
    .clean_err_o   (clean_err)
`endif
  );

`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
  // LUT read model: one-cycle latency, optionally a stuck word at address 3.
  always @(posedge clk) begin
    if (lut_rd_en)
      lut_rd_data <= (bad_word && lut_rd_addr == 4'd3) ? {32'h0, 32'h0, 32'h0000_0100, 32'h0} : '0;
  end
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps through clean writes for addresses first..last, checking each one.
  task automatic clean_writes(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tick();
      check($sformatf("clean_en[%0d]", i), lut_wr_en, 4'hF);
      check($sformatf("clean_addr[%0d]", i), lut_wr_addr, i);
      check($sformatf("clean_data[%0d]", i), lut_wr_data, 0);
      check($sformatf("clean_busy[%0d]", i), clean_done, 0);
      if (i < DEPTH - 1) check($sformatf("clean_ready[%0d]", i), ext_wr.ready, 0);
    end
  endtask

  // Called right after the last clean write is on the outputs.
  task automatic finish_clean();
    check("done_late", clean_done, 0);
    repeat (EXTRA) tick();
    tick();
    check("done_rise", clean_done, 1);
    check("done_en", lut_wr_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ext_wr.valid = 1'b0;
    ext_wr.sel   = '0;
    ext_wr.addr  = '0;
    ext_wr.data  = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_done", clean_done, 0);
    check("rst_en", lut_wr_en, 0);
    check("rst_addr", lut_wr_addr, 0);
    check("rst_data", lut_wr_data, 0);
    check("rst_ready", ext_wr.ready, 0);
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
    check("rst_err", clean_err, 0);
`endif

    // Automatic clean after reset release
    rst_n = 1'b1;
    clean_writes(0, DEPTH - 1);
    finish_clean();
`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
    check("auto_err", clean_err, 0);
`endif

    // External write in IDLE
    ext_wr.valid = 1'b1;
    ext_wr.sel   = 4'b0010;
    ext_wr.addr  = 4'd5;
    ext_wr.data  = 32'hA5;
    #1 check("ext_ready", ext_wr.ready, 1);
    tick();
    ext_wr.valid = 1'b0;
    check("ext_en", lut_wr_en, 4'b0010);
    check("ext_addr", lut_wr_addr, 5);
    check("ext_data", lut_wr_data, 32'hA5);
    tick();
    check("ext_en_off", lut_wr_en, 0);

    // Restart while the clean is at address 7
    clean_stb = 1'b1;
    #1 check("stb_ready", ext_wr.ready, 0);
    tick();
    clean_stb = 1'b0;
    check("stb_done_fall", clean_done, 0);
    check("stb_en_gap", lut_wr_en, 0);
    clean_writes(0, 7);
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    check("restart_addr", lut_wr_addr, 0);
    check("restart_en", lut_wr_en, 4'hF);
    clean_writes(1, DEPTH - 1);
    finish_clean();

    // Strobe and write together in IDLE; write held through the clean
    clean_stb    = 1'b1;
    ext_wr.valid = 1'b1;
    ext_wr.sel   = 4'b1001;
    ext_wr.addr  = 4'd9;
    ext_wr.data  = 32'hDEAD_BEEF;
    #1 check("both_ready", ext_wr.ready, 0);
    tick();
    clean_stb = 1'b0;
    check("both_en", lut_wr_en, 0);
    check("both_done", clean_done, 0);
    check("both_ready2", ext_wr.ready, 0);
    clean_writes(0, DEPTH - 1);
    repeat (EXTRA) begin
      check("hold_ready", ext_wr.ready, 0);
      tick();
    end
    check("idle_ready", ext_wr.ready, 1);
    check("idle_done", clean_done, 0);
    tick();
    ext_wr.valid = 1'b0;
    check("held_en", lut_wr_en, 4'b1001);
    check("held_addr", lut_wr_addr, 9);
    check("held_data", lut_wr_data, 32'hDEAD_BEEF);
    check("held_done", clean_done, 1);
    tick();
    check("held_en_off", lut_wr_en, 0);

    // Reset in the middle of a clean
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    clean_writes(0, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_en", lut_wr_en, 0);
    check("midrst_addr", lut_wr_addr, 0);
    check("midrst_done", clean_done, 0);
    tick();
    check("midrst_hold", lut_wr_en, 0);
    rst_n = 1'b1;
    clean_writes(0, DEPTH - 1);
    finish_clean();

`ifdef BLOOM_FILTER_CLEAN_VERIFY_EN
    // Nonzero read-back at address 3 sets the sticky error
    bad_word  = 1'b1;
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    clean_writes(0, DEPTH - 1);
    finish_clean();
    check("verify_err_set", clean_err, 1);
    tick();
    check("verify_err_sticky", clean_err, 1);
    bad_word  = 1'b0;
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    check("verify_err_clr", clean_err, 0);
    clean_writes(0, DEPTH - 1);
    finish_clean();
    check("verify_err_clean", clean_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
